// File: rtl/decoder_pkg.sv
// Shared types, encodings and opcode decode tables for the instruction sequencer.
// Optional trap on illegal opcodes is enabled by DECODER_ILLEGAL_TRAP_EN.
package decoder_pkg;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    OP1   = 3'd1,
    OP2   = 3'd2,
    EXEC  = 3'd3,
    TRAP  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    AM_IMP,
    AM_IMM,
    AM_ZP,
    AM_REL,
    AM_ABS
  } amode_t;

  localparam logic [3:0] ALU_PASS = 4'd0;
  localparam logic [3:0] ALU_ADC  = 4'd1;
  localparam logic [3:0] ALU_INC  = 4'd2;
  localparam logic [3:0] ALU_CLC  = 4'd4;
  localparam logic [3:0] ALU_SEC  = 4'd5;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_NE   = 3'd1;

  localparam logic [1:0] MUX_NONE = 2'd0;
  localparam logic [1:0] MUX_IMM  = 2'd1;
  localparam logic [1:0] MUX_MEM  = 2'd2;

  localparam logic [7:0] OP_ADC_IMM = 8'h69;
  localparam logic [7:0] OP_ADC_ZP  = 8'h65;
  localparam logic [7:0] OP_ADC_ABS = 8'h6D;
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDA_ZP  = 8'hA5;
  localparam logic [7:0] OP_LDA_ABS = 8'hAD;
  localparam logic [7:0] OP_TAX     = 8'hAA;
  localparam logic [7:0] OP_TAY     = 8'hA8;
  localparam logic [7:0] OP_INX     = 8'hE8;
  localparam logic [7:0] OP_INY     = 8'hC8;
  localparam logic [7:0] OP_CLC     = 8'h18;
  localparam logic [7:0] OP_SEC     = 8'h38;
  localparam logic [7:0] OP_JMP     = 8'h4C;
  localparam logic [7:0] OP_BNE     = 8'hD0;
  localparam logic [7:0] OP_NOP     = 8'hEA;

  typedef struct packed {
    logic       w_rd;
    logic       pc_data;
    logic       x_con;
    logic       y_con;
    logic       acc_con;
    logic       status_con;
    logic       sp_con;
    logic       br_uncon;
    logic       br_con;
    logic [2:0] br_op;
    logic [3:0] alu_op;
    logic [1:0] mux;
  } ctrl_t;

  function automatic logic op_legal(logic [7:0] op);
    case (op)
      OP_ADC_IMM, OP_ADC_ZP, OP_ADC_ABS,
      OP_LDA_IMM, OP_LDA_ZP, OP_LDA_ABS,
      OP_TAX, OP_TAY, OP_INX, OP_INY,
      OP_CLC, OP_SEC, OP_JMP, OP_BNE,
      OP_NOP:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Unknown opcodes fall back to implied so they run as a NOP.
  function automatic amode_t op_mode(logic [7:0] op);
    case (op)
      OP_ADC_IMM, OP_LDA_IMM: return AM_IMM;
      OP_ADC_ZP, OP_LDA_ZP:   return AM_ZP;
      OP_BNE:                 return AM_REL;
      OP_ADC_ABS, OP_LDA_ABS,
      OP_JMP:                 return AM_ABS;
      default:                return AM_IMP;
    endcase
  endfunction

  function automatic ctrl_t op_ctrl(logic [7:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADC_IMM: begin
        c.alu_op = ALU_ADC; c.acc_con = 1'b1;
        c.status_con = 1'b1; c.mux = MUX_IMM;
      end
      OP_ADC_ZP, OP_ADC_ABS: begin
        c.alu_op = ALU_ADC; c.acc_con = 1'b1;
        c.status_con = 1'b1; c.mux = MUX_MEM;
        c.pc_data = 1'b1;
      end
      OP_LDA_IMM: begin
        c.alu_op = ALU_PASS; c.acc_con = 1'b1;
        c.status_con = 1'b1; c.mux = MUX_IMM;
      end
      OP_LDA_ZP, OP_LDA_ABS: begin
        c.alu_op = ALU_PASS; c.acc_con = 1'b1;
        c.status_con = 1'b1; c.mux = MUX_MEM;
        c.pc_data = 1'b1;
      end
      OP_TAX: c.x_con = 1'b1;
      OP_TAY: c.y_con = 1'b1;
      OP_INX: begin
        c.alu_op = ALU_INC; c.x_con = 1'b1;
        c.status_con = 1'b1;
      end
      OP_INY: begin
        c.alu_op = ALU_INC; c.y_con = 1'b1;
        c.status_con = 1'b1;
      end
      OP_CLC: begin
        c.alu_op = ALU_CLC; c.status_con = 1'b1;
      end
      OP_SEC: begin
        c.alu_op = ALU_SEC; c.status_con = 1'b1;
      end
      OP_JMP: c.br_uncon = 1'b1;
      OP_BNE: begin
        c.br_con = 1'b1; c.br_op = BR_NE;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instr_queue.sv
// Instruction-byte prefetch FIFO; QDEPTH must be a power of two.
// An extra pointer bit separates the full and empty cases.
module instr_queue #(
  parameter int DATA_W = 8,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(QDEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [QDEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  assign do_push = push && !full && !rst && !flush;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/decoder_seq.sv
// Fetch/operand/execute sequencer fed by a prefetch queue.
// Define DECODER_ILLEGAL_TRAP_EN to trap on illegal opcodes.
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              normal,
  input  logic              ib_valid,
  input  logic [DATA_W-1:0] ib_data,
  output logic              ib_ready,
  output logic              w_rd,
  output logic              pc_data,
  output logic              increment,
  output logic              lower_byte,
  output logic              x_con,
  output logic              y_con,
  output logic              accumulator_con,
  output logic              status_con,
  output logic              stack_pointer_con,
  output logic              branch_uncon,
  output logic              branch_con,
  output logic [2:0]        branch_op,
  output logic [3:0]        alu_op,
  output logic [1:0]        operand_mux_con,
  output logic [DATA_W-1:0] operand_lo,
  output logic [DATA_W-1:0] operand_hi,
  output logic [1:0]        t_state,
  output logic              busy,
  output logic              illegal
);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] q_dout;
  logic              q_full;
  logic              q_empty;
  logic              push;
  logic              pop_req;
  logic              pop;
  logic              exec_on;
  ctrl_t             ctrl;

  assign ib_ready = !q_full && !flush && !rst;
  assign push     = ib_valid && ib_ready;
  assign pop      = pop_req && !flush && !rst;

  instr_queue #(
    .DATA_W(DATA_W),
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .push (push),
    .pop  (pop),
    .din  (ib_data),
    .dout (q_dout),
    .full (q_full),
    .empty(q_empty)
  );

  always_comb begin
    state_nxt = state;
    pop_req   = 1'b0;
    if (normal) begin
      unique case (state)
        FETCH: begin
          if (!q_empty) begin
            pop_req = 1'b1;
`ifdef DECODER_ILLEGAL_TRAP_EN
            if (!op_legal(q_dout))
              state_nxt = TRAP;
            else if (op_mode(q_dout) == AM_IMP)
              state_nxt = EXEC;
            else
              state_nxt = OP1;
`else
            if (op_mode(q_dout) == AM_IMP)
              state_nxt = EXEC;
            else
              state_nxt = OP1;
`endif
          end
        end
        OP1: begin
          if (!q_empty) begin
            pop_req   = 1'b1;
            state_nxt = (op_mode(ir) == AM_ABS) ? OP2 : EXEC;
          end
        end
        OP2: begin
          if (!q_empty) begin
            pop_req   = 1'b1;
            state_nxt = EXEC;
          end
        end
        EXEC:    state_nxt = FETCH;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      ir         <= DATA_W'(OP_NOP);
      operand_lo <= '0;
      operand_hi <= '0;
    end else if (flush) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
      if (pop && state == FETCH) ir         <= q_dout;
      if (pop && state == OP1)   operand_lo <= q_dout;
      if (pop && state == OP2)   operand_hi <= q_dout;
    end
  end

  // Decoded controls only leave the block while actually executing.
  assign exec_on = (state == EXEC) && normal && !flush && !rst;

  always_comb begin
    ctrl = '0;
    if (exec_on) ctrl = op_ctrl(ir);
  end

  assign w_rd              = ctrl.w_rd;
  assign pc_data           = ctrl.pc_data;
  assign x_con             = ctrl.x_con;
  assign y_con             = ctrl.y_con;
  assign accumulator_con   = ctrl.acc_con;
  assign status_con        = ctrl.status_con;
  assign stack_pointer_con = ctrl.sp_con;
  assign branch_uncon      = ctrl.br_uncon;
  assign branch_con        = ctrl.br_con;
  assign branch_op         = ctrl.br_op;
  assign alu_op            = ctrl.alu_op;
  assign operand_mux_con   = ctrl.mux;

  assign increment  = pop;
  assign lower_byte = pop && (state == OP1);
  assign t_state    = state[1:0];
  assign busy       = (state != FETCH);

`ifdef DECODER_ILLEGAL_TRAP_EN
  assign illegal = (state == TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq: opcode table plus multi-cycle corner cases.
// Follows DECODER_ILLEGAL_TRAP_EN for the illegal-opcode sequence.
module tb_decoder_seq;

  logic       clk = 1'b0;
  logic       rst, flush, normal, ib_valid;
  logic [7:0] ib_data;
  logic       ib_ready, w_rd, pc_data, increment, lower_byte;
  logic       x_con, y_con, accumulator_con, status_con;
  logic       stack_pointer_con, branch_uncon, branch_con;
  logic [2:0] branch_op;
  logic [3:0] alu_op;
  logic [1:0] operand_mux_con;
  logic [7:0] operand_lo, operand_hi;
  logic [1:0] t_state;
  logic       busy, illegal;

  always #5 clk = ~clk;

  decoder_seq #(.DATA_W(8), .QDEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .normal(normal),
    .ib_valid(ib_valid), .ib_data(ib_data), .ib_ready(ib_ready),
    .w_rd(w_rd), .pc_data(pc_data), .increment(increment),
    .lower_byte(lower_byte), .x_con(x_con), .y_con(y_con),
    .accumulator_con(accumulator_con), .status_con(status_con),
    .stack_pointer_con(stack_pointer_con),
    .branch_uncon(branch_uncon), .branch_con(branch_con),
    .branch_op(branch_op), .alu_op(alu_op),
    .operand_mux_con(operand_mux_con),
    .operand_lo(operand_lo), .operand_hi(operand_hi),
    .t_state(t_state), .busy(busy), .illegal(illegal)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  op;
    int          nb;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [17:0] ctrl;
    logic [17:0] mask;
    int          ticks;
  } vec_t;

  vec_t vt[15];

  localparam logic [17:0] ALL = 18'h3ffff;
  localparam logic [17:0] JMPM = 18'h2fffc;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    ib_valid = 1'b1;
    ib_data  = b;
    tick();
    ib_valid = 1'b0;
  endtask

  task automatic wait_exec(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (t_state != 2'd3 && n < 12);
    chk(name, 32'(t_state), 32'd3);
  endtask

  function automatic logic [17:0] ctrl_now();
    return {w_rd, pc_data, x_con, y_con, accumulator_con,
            status_con, stack_pointer_con, branch_uncon,
            branch_con, branch_op, alu_op, operand_mux_con};
  endfunction

  function automatic logic [17:0] mk(
    input bit pc, x, y, acc, st, bu, bc,
    input logic [2:0] bop, input logic [3:0] alu,
    input logic [1:0] mux);
    return {1'b0, pc, x, y, acc, st, 1'b0, bu, bc,
            bop, alu, mux};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int pops, lows, n;
    vt[0]  = '{8'h69, 1, 8'h05, 8'h00,
               mk(0,0,0,1,1,0,0,3'd0,4'd1,2'd1), ALL, 2};
    vt[1]  = '{8'h65, 1, 8'h10, 8'h00,
               mk(1,0,0,1,1,0,0,3'd0,4'd1,2'd2), ALL, 2};
    vt[2]  = '{8'h6D, 2, 8'h20, 8'h30,
               mk(1,0,0,1,1,0,0,3'd0,4'd1,2'd2), ALL, 3};
    vt[3]  = '{8'hA9, 1, 8'h44, 8'h00,
               mk(0,0,0,1,1,0,0,3'd0,4'd0,2'd1), ALL, 2};
    vt[4]  = '{8'hA5, 1, 8'h55, 8'h00,
               mk(1,0,0,1,1,0,0,3'd0,4'd0,2'd2), ALL, 2};
    vt[5]  = '{8'hAD, 2, 8'h66, 8'h77,
               mk(1,0,0,1,1,0,0,3'd0,4'd0,2'd2), ALL, 3};
    vt[6]  = '{8'hAA, 0, 8'h00, 8'h00,
               mk(0,1,0,0,0,0,0,3'd0,4'd0,2'd0), ALL, 1};
    vt[7]  = '{8'hA8, 0, 8'h00, 8'h00,
               mk(0,0,1,0,0,0,0,3'd0,4'd0,2'd0), ALL, 1};
    vt[8]  = '{8'hE8, 0, 8'h00, 8'h00,
               mk(0,1,0,0,1,0,0,3'd0,4'd2,2'd0), ALL, 1};
    vt[9]  = '{8'hC8, 0, 8'h00, 8'h00,
               mk(0,0,1,0,1,0,0,3'd0,4'd2,2'd0), ALL, 1};
    vt[10] = '{8'h18, 0, 8'h00, 8'h00,
               mk(0,0,0,0,1,0,0,3'd0,4'd4,2'd0), ALL, 1};
    vt[11] = '{8'h38, 0, 8'h00, 8'h00,
               mk(0,0,0,0,1,0,0,3'd0,4'd5,2'd0), ALL, 1};
    vt[12] = '{8'h4C, 2, 8'h88, 8'h99,
               mk(0,0,0,0,0,1,0,3'd0,4'd0,2'd0), JMPM, 3};
    vt[13] = '{8'hD0, 1, 8'hFE, 8'h00,
               mk(0,0,0,0,0,0,1,3'd1,4'd0,2'd0), ALL, 2};
    vt[14] = '{8'hEA, 0, 8'h00, 8'h00,
               mk(0,0,0,0,0,0,0,3'd0,4'd0,2'd0), ALL, 1};

    rst = 1'b1; flush = 1'b0; normal = 1'b1;
    ib_valid = 1'b0; ib_data = 8'h00;
    tick(); tick();
    chk("rst_ctrl", 32'(ctrl_now()), 0);
    chk("rst_inc", 32'(increment), 0);
    rst = 1'b0;
    #1;
    chk("rst_state", 32'(t_state), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_ready", 32'(ib_ready), 1);
    chk("rst_lo_hi", {16'h0, operand_hi, operand_lo}, 0);
    chk("post_rst_ctrl", 32'(ctrl_now()), 0);

    // ADC #05 streamed in behind its opcode.
    push_byte(8'h69);
    chk("adc_fetch", {t_state, increment}, {2'd0, 1'b1});
    push_byte(8'h05);
    chk("adc_op1", {t_state, lower_byte}, {2'd1, 1'b1});
    tick();
    chk("adc_exec", {t_state, alu_op, accumulator_con,
        operand_mux_con, operand_lo},
        {2'd3, 4'd1, 1'b1, 2'd1, 8'h05});
    tick();

    // ADC abs with operand bytes arriving late.
    push_byte(8'h6D);
    chk("stall_fetch", {t_state, increment}, {2'd0, 1'b1});
    tick(); tick(); tick();
    chk("stall_op1", {t_state, increment}, {2'd1, 1'b0});
    push_byte(8'h34);
    chk("late_lo_pop", {t_state, lower_byte}, {2'd1, 1'b1});
    push_byte(8'h12);
    chk("late_hi_pop", {t_state, increment, lower_byte},
        {2'd2, 1'b1, 1'b0});
    tick();
    chk("abs_exec", {t_state, pc_data, operand_mux_con,
        operand_hi, operand_lo},
        {2'd3, 1'b1, 2'd2, 8'h12, 8'h34});
    tick();

    for (int i = 0; i < 15; i++) begin
      normal = 1'b0;
      push_byte(vt[i].op);
      if (vt[i].nb >= 1) push_byte(vt[i].b1);
      if (vt[i].nb >= 2) push_byte(vt[i].b2);
      normal = 1'b1;
      #1;
      pops = int'(increment);
      lows = int'(lower_byte);
      n = 0;
      while (t_state != 2'd3 && n < 8) begin
        tick();
        n++;
        pops += int'(increment);
        lows += int'(lower_byte);
      end
      chk($sformatf("cyc_%02h", vt[i].op), n, vt[i].ticks);
      chk($sformatf("ctrl_%02h", vt[i].op),
          32'(ctrl_now() & vt[i].mask),
          32'(vt[i].ctrl & vt[i].mask));
      chk($sformatf("pops_%02h", vt[i].op), pops, vt[i].nb + 1);
      chk($sformatf("lows_%02h", vt[i].op), lows,
          (vt[i].nb > 0) ? 1 : 0);
      if (vt[i].nb >= 1)
        chk($sformatf("lo_%02h", vt[i].op), 32'(operand_lo),
            32'(vt[i].b1));
      if (vt[i].nb >= 2)
        chk($sformatf("hi_%02h", vt[i].op), 32'(operand_hi),
            32'(vt[i].b2));
      tick();
      chk($sformatf("back_%02h", vt[i].op), 32'(t_state), 0);
    end

    // Fill the queue while frozen, then release.
    normal = 1'b0;
    ib_valid = 1'b1;
    ib_data = 8'hA9; tick();
    ib_data = 8'h11; tick();
    ib_data = 8'hA9; tick();
    chk("q3_ready", 32'(ib_ready), 1);
    ib_data = 8'h22; tick();
    chk("q4_full", 32'(ib_ready), 0);
    ib_data = 8'hEA; tick();
    chk("q_hold", {t_state, ib_ready}, {2'd0, 1'b0});
    normal = 1'b1;
    tick();
    chk("q_after_pop", {t_state, ib_ready}, {2'd1, 1'b1});
    tick();
    ib_valid = 1'b0;
    chk("q_lda1", {t_state, operand_lo}, {2'd3, 8'h11});
    wait_exec("q_exec2");
    chk("q_lda2", {accumulator_con, operand_lo}, {1'b1, 8'h22});
    wait_exec("q_exec3");
    chk("q_nop", 32'(ctrl_now()), 0);
    tick();
    chk("q_drained", {t_state, increment}, {2'd0, 1'b0});

    // Freeze while in EXEC.
    normal = 1'b0;
    push_byte(8'hE8);
    normal = 1'b1;
    tick();
    normal = 1'b0;
    #1;
    chk("frz_ctrl", {t_state, 16'(ctrl_now())}, {2'd3, 16'h0});
    tick();
    chk("frz_hold", 32'(t_state), 3);
    normal = 1'b1;
    #1;
    chk("frz_release", {x_con, status_con, alu_op},
        {1'b1, 1'b1, 4'd2});
    tick();
    chk("frz_back", 32'(t_state), 0);

    // Reset in the middle of an instruction.
    normal = 1'b0;
    push_byte(8'h6D);
    push_byte(8'h01);
    normal = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_out", {ctrl_now(), increment}, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_after", {t_state, operand_lo, ib_ready, increment},
        {2'd0, 8'h00, 1'b1, 1'b0});
    tick();
    chk("mid_rst_idle", 32'(t_state), 0);

    // Flush while waiting for operand_hi; same-cycle push dropped.
    normal = 1'b0;
    push_byte(8'hAD);
    push_byte(8'h00);
    normal = 1'b1;
    tick(); tick();
    chk("fl_op2", {t_state, increment}, {2'd2, 1'b0});
    flush = 1'b1;
    ib_valid = 1'b1;
    ib_data = 8'hE8;
    #1;
    chk("fl_ready", {ib_ready, 18'(ctrl_now())}, 0);
    tick();
    flush = 1'b0;
    ib_valid = 1'b0;
    #1;
    chk("fl_after", {t_state, increment, busy}, 0);
    tick(); tick();
    chk("fl_idle", {t_state, 18'(ctrl_now())}, 0);

    // Illegal opcode followed by NOP.
    normal = 1'b0;
    push_byte(8'hFF);
    push_byte(8'hEA);
    normal = 1'b1;
    #1;
    chk("ill_pop", 32'(increment), 1);
    tick();
`ifdef DECODER_ILLEGAL_TRAP_EN
    chk("trap_enter", {t_state, busy, illegal},
        {2'd3, 1'b1, 1'b1});
    tick(); tick(); tick();
    chk("trap_hold", {t_state, illegal, increment},
        {2'd3, 1'b1, 1'b0});
    chk("trap_ctrl", 32'(ctrl_now()), 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("trap_exit", {t_state, illegal, increment}, 0);
`else
    chk("ill_exec", {t_state, illegal, 18'(ctrl_now())},
        {2'd3, 1'b0, 18'h0});
    tick();
    chk("ill_next", {t_state, increment}, {2'd0, 1'b1});
    tick();
    chk("ill_nop", {t_state, illegal}, {2'd3, 1'b0});
    tick();
    chk("ill_done", {t_state, increment}, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 Parameter DATA_W, default 8, instruction/operand byte width.
REQ-002 Parameter QDEPTH, default 4, prefetch queue depth (power of two, >=2).
REQ-003 Port clk  in  1  single system clock; all state updates on rising edge.
REQ-004 Port rst  in  1  reset, synchronous, active-high.
REQ-005 Port flush  in  1  discard queue and abort current instruction.
REQ-006 Port normal  in  1  run enable; 0 freezes sequencer and queue pops.
REQ-007 Ports ib_valid in 1, ib_data in DATA_W, ib_ready out 1  instruction-byte push handshake.
REQ-008 Ports w_rd, pc_data, increment, lower_byte  out  1 each  memory/PC controls.
REQ-009 Ports x_con, y_con, accumulator_con, status_con, stack_pointer_con  out  1 each  register load enables.
REQ-010 Ports branch_uncon, branch_con  out 1; branch_op out 3; alu_op out 4; operand_mux_con out 2.
REQ-011 Ports operand_lo, operand_hi  out  DATA_W  latched operand bytes.
REQ-012 Ports t_state out 2 (current FSM state), busy out 1 (state != FETCH), illegal out 1.

Function
REQ-013 Queue push occurs when ib_valid && ib_ready; ib_ready = !full && !flush.
REQ-014 States FETCH(0), OP1(1), OP2(2), EXEC(3); all transitions gated by normal=1.
REQ-015 FETCH: if queue non-empty, pop opcode into IR, go to EXEC (implied) or OP1 (imm/zp/rel/abs); else stay.
REQ-016 OP1: if non-empty pop operand_lo, go to OP2 (abs) or EXEC; if empty, hold state (stall).
REQ-017 OP2: if non-empty pop operand_hi, go to EXEC; if empty, hold.
REQ-018 EXEC: lasts exactly one cycle, then FETCH; no pop in EXEC.
REQ-019 Cycle counts with queue never empty: implied 2, imm/zp/rel 3, abs 4.
REQ-020 increment high exactly in cycles where a byte is popped; lower_byte high only on OP1 pop.
REQ-021 Control outputs other than increment/lower_byte are zero except in EXEC, where they follow the opcode table.
REQ-022 Table: 69/65/6D ADC (alu_op=1, accumulator_con, status_con); A9/A5/AD LDA (alu_op=0, accumulator_con, status_con); AA TAX (x_con); A8 TAY (y_con); E8 INX, C8 INY (alu_op=2, x_con/y_con, status_con); 18 CLC, 38 SEC (status_con, alu_op=4/5); 4C JMP (branch_uncon); D0 BNE (branch_con, branch_op=1); EA NOP (none).
REQ-023 In EXEC, pc_data=1 for zp/abs data modes; operand_mux_con=1 imm, 2 memory, 0 otherwise; w_rd=0 (read) for all listed opcodes.
REQ-024 Any opcode absent from REQ-022 is illegal: handled per REQ-031.
REQ-025 flush (highest priority after rst): queue emptied, FSM to FETCH, all controls zero next cycle; a same-cycle push is dropped.
REQ-026 normal=0 mid-instruction: state, IR, operands held; EXEC outputs forced zero while frozen; pushes still accepted.
REQ-027 Queue full: ib_ready=0; simultaneous pop and push when not full both occur; pointers wrap modulo QDEPTH.

Reset
REQ-028 rst: queue empty, FSM FETCH, IR=EA, operand_lo/hi=0, illegal=0.
REQ-029 All control outputs zero during and one cycle after rst; ib_ready=1 first cycle after rst.
REQ-030 rst mid-instruction aborts it with no EXEC outputs produced.

Configuration
REQ-031 Macro DECODER_ILLEGAL_TRAP_EN defined: illegal opcode enters TRAP (t_state=3, busy=1), illegal held 1, no pops, exit only via rst or flush; undefined: illegal opcode executes as 2-cycle NOP and illegal is tied 0.

Structure
REQ-032 Package decoder_pkg holds state enum, addressing-mode enum, alu_op and branch_op encodings, opcode constants.
REQ-033 Sub-module instr_queue (parametrised FIFO, DATA_W x QDEPTH) with push/pop/full/empty/flush.

Verification
REQ-034 Push 69,05 after reset -> FETCH,OP1,EXEC; EXEC: alu_op=1, accumulator_con=1, operand_mux_con=1, operand_lo=05.
REQ-035 Push 6D only, then 34 after 3 cycles, then 12 -> stalls in OP1/OP2; EXEC with operand_lo=34, operand_hi=12, pc_data=1.
REQ-036 Push 4 bytes with ib_valid held, normal=0 -> ib_ready=0 after fourth push; fifth byte accepted only after first pop.
REQ-037 Push AD,00 then flush in OP2 -> next cycle t_state=0, queue empty, no EXEC outputs.
REQ-038 Push FF then EA -> with DECODER_ILLEGAL_TRAP_EN: illegal=1 held, EA never popped; without: 2-cycle NOP, illegal=0, EA executes next.
